pp_header_collector: RTL and testbench
======================================

// Module: pp_header_collector
// PURPOSE
//  Front stage of the packet parser. Consumes a byte-wide AXI-Stream packet and
//  assembles its first HDR_BYTES bytes into one header slice for the parser.
//  Forwards the remaining payload bytes unchanged on a byte stream, then emits
//  one total-length record per packet for metadata assembly.
// PARAMETERS
//  TDATA_WIDTH     8      stream byte width; fixed at 8, other values unsupported
//  HDR_BYTES       16     header slice size in bytes (slice width = 8*HDR_BYTES = 128)
//  LEN_WIDTH       16     packet length counter width
//  MAX_PKT_LENGTH  65535  largest legal packet in bytes; must be <= 2**LEN_WIDTH-1
// PORTS
//  aclk            in   1         clock
//  aresetn         in   1         async active-low reset
//  s_axis_tdata    in   8         input byte
//  s_axis_tvalid   in   1         input beat valid
//  s_axis_tready   out  1         input beat accepted when tvalid&tready
//  s_axis_tlast    in   1         last byte of packet
//  hdr_tdata       out  8*HDR_BYTES  header slice; first byte at MSBs [127:120]
//  hdr_bytes       out  5         number of valid header bytes, 1..HDR_BYTES
//  hdr_short       out  1         packet ended before header filled
//  hdr_tvalid      out  1         header slice valid
//  hdr_tready      in   1         header slice consumed
//  m_axis_tdata    out  8         payload byte (bytes after the header)
//  m_axis_tvalid   out  1         payload beat valid
//  m_axis_tready   in   1         payload beat consumed
//  m_axis_tlast    out  1         last payload byte
//  len_tdata       out  LEN_WIDTH total packet bytes, header included
//  len_err         out  1         packet exceeded MAX_PKT_LENGTH
//  len_tvalid      out  1         length record valid
//  len_tready      in   1         length record consumed
// BEHAVIOUR
//  Reset (async, aresetn low): state=S_HDR; byte_cnt=0, len_cnt=0, len_err=0;
//   hdr_tdata=0, hdr_bytes=0, hdr_short=0; all *_tvalid=0; s_axis_tready=0 while reset asserted.
//  States: S_HDR -> S_HDR_OUT -> {S_PAY | S_LEN} ; S_PAY -> S_LEN ; S_LEN -> S_HDR.
//  S_HDR: s_axis_tready=1. Each accepted byte is written to slice byte lane byte_cnt (MSB-first).
//   byte_cnt and len_cnt increment. Unwritten lanes stay 0 (cleared on S_LEN exit).
//   Accepted byte with tlast and byte_cnt+1 < HDR_BYTES -> hdr_short=1, S_HDR_OUT, then S_LEN.
//   Accepted byte that fills lane HDR_BYTES-1 -> S_HDR_OUT; next state is S_LEN if that byte
//   had tlast, otherwise S_PAY. hdr_bytes = byte_cnt+1 at transition.
//  S_HDR_OUT: hdr_tvalid=1, s_axis_tready=0. Outputs stable until hdr_tready.
//   Leaves the state on the hdr_tvalid&hdr_tready cycle.
//  S_PAY: combinational pass-through, zero latency. m_axis_tdata/tvalid/tlast = s_axis_*.
//   s_axis_tready = m_axis_tready. len_cnt increments per accepted beat.
//   Accepted tlast -> S_LEN. Packets <= HDR_BYTES produce no m_axis beat.
//  S_LEN: len_tvalid=1, s_axis_tready=0. len_tdata=len_cnt, len_err sticky for the packet.
//   On len_tready -> S_HDR; clear byte_cnt, len_cnt, len_err, hdr_tdata, hdr_short.
//  Length arithmetic: len_cnt saturates at MAX_PKT_LENGTH and never wraps.
//   Any accepted byte while len_cnt==MAX_PKT_LENGTH sets len_err=1.
//   Payload is still forwarded up to tlast.
//  hdr_tvalid, m_axis_tvalid and len_tvalid are never high in the same cycle.
//   Output order per packet is always header, then payload, then length.
//  s_axis_tvalid low in any state: no counter change, no state change.
//  Reset mid-packet: partial packet discarded, no tlast/header/length emitted for it.
//   First byte after reset is treated as byte 0 of a new packet.
// TESTING
//  T1 40-byte pkt 0x00..0x27 -> hdr_tdata=0x000102..0F, bytes=16, short=0;
//     24 m_axis beats 0x10..0x27, tlast on 0x27; len=40, err=0
//  T2 5-byte pkt AA BB CC DD EE -> hdr_tdata=0xAABBCCDDEE followed by 22 zero nibbles,
//     bytes=5, short=1; no m_axis beat; len=5
//  T3 exactly 16 bytes and 1-byte pkt 0x5A -> first: short=0, bytes=16, no payload, len=16;
//     second: hdr=0x5A<<120, bytes=1, short=1, len=1
//  T4 hdr_tready low 10 cycles, then m_axis_tready toggled 1/0 -> s_axis_tready low all
//     10 cycles then mirrors m_axis_tready; no byte lost or duplicated (scoreboard)
//  T5 70000-byte pkt -> all 69984 payload bytes forwarded; len=65535, len_err=1;
//     next pkt len_err=0
//  T6 aresetn pulsed low mid-payload -> same cycle all tvalid=0; after release 3-byte pkt
//     01 02 03 -> hdr=0x010203<<104, bytes=3, len=3

Source files
------------

// File: rtl/pp_header_collector.sv
// pp_header_collector: front stage of the packet parser. Collects the first
// HDR_BYTES bytes of each byte-wide packet into one header slice. It then
// passes the remaining payload straight through and finishes with one length
// record per packet. Each packet produces its outputs in the order header,
// payload, length.

// One byte lane of the header slice. A lane keeps its value until it is
// cleared at the end of the packet.
module pp_hdr_lane #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         clr,
  input  logic         wr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // lane storage: write on header byte, clear when the length record leaves
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)  q <= '0;
    else if (clr)  q <= '0;
    else if (wr)   q <= d;
  end
endmodule

module pp_header_collector #(
  parameter int TDATA_WIDTH    = 8,
  parameter int HDR_BYTES      = 16,
  parameter int LEN_WIDTH      = 16,
  parameter int MAX_PKT_LENGTH = 65535
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [TDATA_WIDTH-1:0]           s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  output logic [TDATA_WIDTH*HDR_BYTES-1:0] hdr_tdata,
  output logic [$clog2(HDR_BYTES+1)-1:0]   hdr_bytes,
  output logic                             hdr_short,
  output logic                             hdr_tvalid,
  input  logic                             hdr_tready,
  output logic [TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [LEN_WIDTH-1:0]             len_tdata,
  output logic                             len_err,
  output logic                             len_tvalid,
  input  logic                             len_tready
);
  localparam int BCW = $clog2(HDR_BYTES+1);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_PKT_LENGTH);

  typedef enum logic [1:0] {S_HDR, S_HDR_OUT, S_PAY, S_LEN} state_t;

  state_t         state, state_nxt;
  logic [BCW-1:0] byte_cnt;
  logic [LEN_WIDTH-1:0] len_cnt;
  logic           pkt_done;   // tlast already seen inside the header
  logic           acc, hdr_acc, hdr_full, hdr_end, len_done;

  logic [HDR_BYTES-1:0][TDATA_WIDTH-1:0] lanes;
  logic [HDR_BYTES-1:0]                  lane_wr;

  assign acc      = s_axis_tvalid & s_axis_tready;
  assign hdr_acc  = acc && (state == S_HDR);
  assign hdr_full = (byte_cnt == BCW'(HDR_BYTES-1));
  assign hdr_end  = hdr_acc && (s_axis_tlast || hdr_full);
  assign len_done = (state == S_LEN) && len_tready;

  // Byte 0 lands in the most significant lane of the slice.
  for (genvar i = 0; i < HDR_BYTES; i++) begin : g_lane
    assign lane_wr[i] = hdr_acc && (byte_cnt == BCW'(i));
    pp_hdr_lane #(.W(TDATA_WIDTH)) u_lane (
      .aclk    (aclk),
      .aresetn (aresetn),
      .clr     (len_done),
      .wr      (lane_wr[i]),
      .d       (s_axis_tdata),
      .q       (lanes[HDR_BYTES-1-i])
    );
  end

  assign hdr_tdata = lanes;
  assign len_tdata = len_cnt;

  // next state and handshake outputs; payload is a zero-latency pass-through
  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    hdr_tvalid    = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    len_tvalid    = 1'b0;
    case (state)
      S_HDR: begin
        // reset sits in this state, so gate ready with reset explicitly
        s_axis_tready = aresetn;
        if (hdr_end) state_nxt = S_HDR_OUT;
      end
      S_HDR_OUT: begin
        hdr_tvalid = 1'b1;
        if (hdr_tready) state_nxt = pkt_done ? S_LEN : S_PAY;
      end
      S_PAY: begin
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        s_axis_tready = m_axis_tready;
        if (acc && s_axis_tlast) state_nxt = S_LEN;
      end
      S_LEN: begin
        len_tvalid = 1'b1;
        if (len_tready) state_nxt = S_HDR;
      end
      default: state_nxt = S_HDR;
    endcase
  end

  // state, counters and header status; everything per-packet clears on length exit
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= S_HDR;
      byte_cnt  <= '0;
      len_cnt   <= '0;
      len_err   <= 1'b0;
      hdr_bytes <= '0;
      hdr_short <= 1'b0;
      pkt_done  <= 1'b0;
    end else begin
      state <= state_nxt;
      // saturate instead of wrapping; an overlong packet is flagged, not truncated
      if (acc) begin
        if (len_cnt == LEN_MAX) len_err <= 1'b1;
        else                    len_cnt <= len_cnt + 1'b1;
      end
      if (hdr_acc) begin
        byte_cnt <= byte_cnt + 1'b1;
        if (hdr_end) begin
          hdr_bytes <= byte_cnt + 1'b1;
          hdr_short <= !hdr_full;
          pkt_done  <= s_axis_tlast;
        end
      end
      if (len_done) begin
        byte_cnt  <= '0;
        len_cnt   <= '0;
        len_err   <= 1'b0;
        hdr_short <= 1'b0;
        pkt_done  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pp_header_collector.sv
// Randomized bench for pp_header_collector. Each expected packet is modelled as
// a byte queue: the header is its first 16 bytes, the payload is the rest, and
// the length is the saturated byte count.
module tb_pp_header_collector;
  typedef logic [7:0] byte_q_t[$];

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [7:0]   s_axis_tdata;
  logic         s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [127:0] hdr_tdata;
  logic [4:0]   hdr_bytes;
  logic         hdr_short, hdr_tvalid, hdr_tready;
  logic [7:0]   m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [15:0]  len_tdata;
  logic         len_err, len_tvalid, len_tready;

  pp_header_collector dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .hdr_tdata(hdr_tdata), .hdr_bytes(hdr_bytes), .hdr_short(hdr_short),
    .hdr_tvalid(hdr_tvalid), .hdr_tready(hdr_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .len_tdata(len_tdata), .len_err(len_err), .len_tvalid(len_tvalid),
    .len_tready(len_tready)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // sink ready pattern: 0 always ready, 1 random, 2 header stall then toggling payload ready
  int rmode = 0;
  int hc = 0;
  initial begin
    hdr_tready = 1'b1; m_axis_tready = 1'b1; len_tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      case (rmode)
        0: begin hdr_tready = 1'b1; m_axis_tready = 1'b1; len_tready = 1'b1; end
        1: begin
          hdr_tready    = $urandom_range(0, 99) < 70;
          m_axis_tready = $urandom_range(0, 99) < 70;
          len_tready    = $urandom_range(0, 99) < 70;
        end
        default: begin
          if (hdr_tvalid) hc++; else hc = 0;
          hdr_tready    = hc > 10;
          m_axis_tready = !m_axis_tready;
          len_tready    = 1'b1;
        end
      endcase
    end
  end

  // scoreboard capture on the falling edge
  byte_q_t      got_pay;
  logic [127:0] g_hdr;
  logic [4:0]   g_hb;
  logic         g_hs, g_err;
  logic [15:0]  g_len;
  int hdr_n, len_n, tlast_n, tlast_idx, hdr_cyc, len_cyc, pay_first, pay_last, stall;
  int cyc = 0, excl_bad = 0, mirror_bad = 0, hv_bad = 0;

  task automatic clr_sb();
    got_pay.delete();
    hdr_n = 0; len_n = 0; tlast_n = 0; tlast_idx = -1; hdr_cyc = -1;
    len_cyc = -1; pay_first = -1; pay_last = -1; stall = 0;
  endtask

  always @(negedge aclk) begin
    cyc++;
    if (aresetn) begin
      if (hdr_tvalid && hdr_tready) begin
        hdr_n++; g_hdr = hdr_tdata; g_hb = hdr_bytes; g_hs = hdr_short; hdr_cyc = cyc;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        got_pay.push_back(m_axis_tdata);
        if (m_axis_tlast) begin tlast_n++; tlast_idx = got_pay.size() - 1; end
        if (pay_first < 0) pay_first = cyc;
        pay_last = cyc;
      end
      if (len_tvalid && len_tready) begin
        len_n++; g_len = len_tdata; g_err = len_err; len_cyc = cyc;
      end
      if (int'(hdr_tvalid) + int'(m_axis_tvalid) + int'(len_tvalid) > 1) excl_bad++;
      if (m_axis_tvalid && (s_axis_tready != m_axis_tready)) mirror_bad++;
      if ((hdr_tvalid || len_tvalid) && s_axis_tready) hv_bad++;
      if (hdr_tvalid && !hdr_tready) stall++;
    end
  end

  // drive one packet; holds each beat until accepted, idle gaps only between beats
  task automatic send_pkt(input byte_q_t b, input int gap, input bit do_last);
    bit acc;
    int t;
    for (int i = 0; i < b.size(); i++) begin
      while (gap > 0 && $urandom_range(0, 99) < gap) begin
        s_axis_tvalid = 1'b0; @(posedge aclk); #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = b[i];
      s_axis_tlast  = do_last && (i == b.size() - 1);
      acc = 1'b0; t = 0;
      while (!acc) begin
        @(negedge aclk); acc = s_axis_tready;
        @(posedge aclk); #1;
        t++;
        if (!acc && t > 2000) begin
          chk("s_timeout", 0, 1);
          s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
          return;
        end
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // send a packet, then compare everything it produced against the byte-queue model
  task automatic run_pkt(input byte_q_t b, input int gap);
    int n, hn, pn, bad, t;
    logic [127:0] eh;
    bit ord;
    clr_sb();
    send_pkt(b, gap, 1'b1);
    t = 0;
    while (len_n == 0 && t < 500) begin @(posedge aclk); #1; t++; end
    n  = b.size();
    hn = (n < 16) ? n : 16;
    pn = n - hn;
    eh = '0;
    for (int i = 0; i < hn; i++) eh[127 - 8*i -: 8] = b[i];
    bad = 0;
    for (int i = 0; i < pn && i < got_pay.size(); i++)
      if (got_pay[i] !== b[16 + i]) bad++;
    ord = (hdr_cyc >= 0) && (hdr_cyc < len_cyc) &&
          (pay_first < 0 || (hdr_cyc < pay_first && pay_last < len_cyc));
    chk("hdr_n", hdr_n, 1);
    chk("hdr_data", g_hdr, eh);
    chk("hdr_bytes", g_hb, hn);
    chk("hdr_short", g_hs, n < 16);
    chk("pay_n", got_pay.size(), pn);
    chk("pay_data", bad, 0);
    chk("tlast_n", tlast_n, pn > 0);
    if (pn > 0) chk("tlast_pos", tlast_idx, pn - 1);
    chk("len_n", len_n, 1);
    chk("len", g_len, (n > 65535) ? 65535 : n);
    chk("len_err", g_err, n > 65535);
    chk("order", ord, 1);
  endtask

  initial begin
    byte_q_t b;
    aresetn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    clr_sb();
    #2;
    s_axis_tvalid = 1'b1;
    #1;
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_tvalids", {hdr_tvalid, m_axis_tvalid, len_tvalid}, 0);
    chk("rst_hdr", hdr_tdata, 0);
    chk("rst_hdr_st", {hdr_bytes, hdr_short}, 0);
    chk("rst_len", {len_tdata, len_err}, 0);
    s_axis_tvalid = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;

    // T1: 40-byte incrementing packet
    b = {}; for (int i = 0; i < 40; i++) b.push_back(8'(i));
    run_pkt(b, 0);
    chk("t1_hdr_lit", g_hdr, 128'h000102030405060708090a0b0c0d0e0f);
    // T2: short 5-byte packet
    b = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_pkt(b, 0);
    chk("t2_hdr_lit", g_hdr, {40'hAABBCCDDEE, 88'h0});
    // T3: exactly one header, then a single byte
    b = {}; for (int i = 0; i < 16; i++) b.push_back(8'($urandom));
    run_pkt(b, 0);
    b = {8'h5A};
    run_pkt(b, 0);
    // T4: header stall then toggling payload ready
    rmode = 2;
    b = {}; for (int i = 0; i < 40; i++) b.push_back(8'($urandom));
    run_pkt(b, 0);
    chk("t4_stall", stall, 10);
    rmode = 0;
    // random lengths, gaps and sink readies
    rmode = 1;
    for (int k = 0; k < 25; k++) begin
      b = {};
      for (int i = 0, n = $urandom_range(1, 40); i < n; i++) b.push_back(8'($urandom));
      run_pkt(b, 25);
    end
    rmode = 0;
    // T5: overlong packet saturates and flags, next packet clean
    b = {}; for (int i = 0; i < 70000; i++) b.push_back(8'(i * 7));
    run_pkt(b, 0);
    b = {}; for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
    run_pkt(b, 0);
    // T6: reset in the middle of the payload
    clr_sb();
    b = {}; for (int i = 0; i < 20; i++) b.push_back(8'(8'h80 + i));
    send_pkt(b, 0, 1'b0);
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h99;
    #1;
    chk("t6_pre_mvalid", m_axis_tvalid, 1);
    #1 aresetn = 1'b0;
    #1;
    chk("t6_tvalids", {hdr_tvalid, m_axis_tvalid, len_tvalid}, 0);
    chk("t6_tready", s_axis_tready, 0);
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    chk("t6_nolen", len_n, 0);
    chk("t6_notlast", tlast_n, 0);
    b = {8'h01, 8'h02, 8'h03};
    run_pkt(b, 0);
    chk("t6_hdr_lit", g_hdr, {24'h010203, 104'h0});

    chk("excl_valid", excl_bad, 0);
    chk("pay_mirror", mirror_bad, 0);
    chk("busy_tready", hv_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
